// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO plus send sequencer in front of uart_byte_tx.
// Producers push bytes at any rate. The sequencer pops one byte, pulses Send_Go
// for one cycle, and then waits for Tx_done before it releases the next byte.
module uart_tx_fifo_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [7:0]        Data,
   output logic              Send_Go,
   input  logic              Tx_done,
   output logic              tx_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT
   } state_t;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [7:0]        mem_q [DEPTH];
   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [ADDR_W:0]   count_q,    count_d;
   logic              full_q,     full_d;
   logic              empty_q,    empty_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        data_q,     data_d;
   logic              send_go_q,  send_go_d;
   logic              busy_q,     busy_d;
   logic              do_write;
   logic              do_pop;

   // Next-state logic for the FIFO bookkeeping and the send sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      data_d  = data_q;
      // The full flag is sampled before any pop, so a pop on the same edge never admits a write into a full FIFO.
      do_write = wr_en && !full_q;
      do_pop   = (state_q == ST_IDLE) && !empty_q;

      case (state_q)
         ST_IDLE: begin
            if (!empty_q) begin
               state_d = ST_START;
               data_d  = mem_q[rd_ptr_q];
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (Tx_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      wr_ptr_d = do_write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      if (do_write && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_write && do_pop) count_d = count_q - CNT_ONE;

      full_d     = (count_d == FULL_CNT);
      empty_d    = (count_d == '0);
      overflow_d = wr_en && full_q;
      send_go_d  = (state_d == ST_START);
      busy_d     = (state_d != ST_IDLE);
   end

   // Byte storage. Only accepted writes update an entry.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset. count gates every read, so a stale entry is never presented.
      if (do_write) mem_q[wr_ptr_q] <= wr_data;
   end

   // State, pointer and registered-output flops, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge values of its neighbours.
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         data_q     <= 8'h00;
         send_go_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         data_q     <= data_d;
         send_go_q  <= send_go_d;
         busy_q     <= busy_d;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign Data     = data_q;
   assign Send_Go  = send_go_q;
   assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Testbench for uart_tx_fifo_feeder.
// The stimulus process pushes the expected byte order into a scoreboard queue.
// A monitor pops that queue and compares it against Data on every Send_Go pulse.
module tb_uart_tx_fifo_feeder;

   logic       clk;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] Data;
   logic       Send_Go;
   logic       Tx_done;
   logic       tx_busy;

   int         vectors     = 0;
   int         miscompares = 0;
   int         sg_count    = 0;
   int         go_expect   = 0;
   logic [7:0] expq [$];

   uart_tx_fifo_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .Data     (Data),
      .Send_Go  (Send_Go),
      .Tx_done  (Tx_done),
      .tx_busy  (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b, input bit accepted);
      wr_data = b;
      wr_en   = 1'b1;
      if (accepted) expq.push_back(b);
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_done();
      Tx_done = 1'b1;
      cyc();
      Tx_done = 1'b0;
   endtask

   // Wait, with a cycle bound, until the monitor has seen the target number of Send_Go pulses.
   task automatic wait_go(input int target);
      int n = 0;
      while (sg_count < target && n < 500) begin
         cyc();
         n++;
      end
      check("send_go_seen", 32'(sg_count >= target), 32'd1);
   endtask

   // Release n transfers in turn, acknowledging each with a short Tx_done delay.
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         go_expect++;
         wait_go(go_expect);
         repeat (3) cyc();
         pulse_done();
      end
   endtask

   // Monitor: compare every presented byte against the scoreboard and check that Data holds while busy.
   initial begin
      logic       prev_go;
      logic [7:0] last_data;
      logic [7:0] exp_b;
      prev_go   = 1'b0;
      last_data = 8'h00;
      forever begin
         @(negedge clk);
         if (Send_Go) begin
            sg_count++;
            check("send_go_single", 32'(prev_go), 32'd0);
            check("busy_with_go", 32'(tx_busy), 32'd1);
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_send_go: Data=%02h, scoreboard empty (t=%0t)", Data, $time);
            end else begin
               exp_b = expq.pop_front();
               check("data_order", 32'(Data), 32'(exp_b));
            end
            last_data = Data;
         end else if (tx_busy) begin
            check("data_hold", 32'(Data), 32'(last_data));
         end
         prev_go = Send_Go;
      end
   end

   // Watchdog: the run ends even if the design hangs.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      Tx_done = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;

      // Reset state.
      check("rst_count",    32'(count),    32'd0);
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_full",     32'(full),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_data",     32'(Data),     32'h00);
      check("rst_send_go",  32'(Send_Go),  32'd0);
      check("rst_busy",     32'(tx_busy),  32'd0);

      // Test 1: latency from the write to Send_Go.
      push(8'hA5, 1'b1);
      check("t1_c1_count",   32'(count),   32'd1);
      check("t1_c1_empty",   32'(empty),   32'd0);
      check("t1_c1_send_go", 32'(Send_Go), 32'd0);
      cyc();
      check("t1_c2_send_go", 32'(Send_Go), 32'd1);
      check("t1_c2_data",    32'(Data),    32'hA5);
      check("t1_c2_busy",    32'(tx_busy), 32'd1);
      check("t1_c2_count",   32'(count),   32'd0);
      cyc();
      check("t1_c3_send_go", 32'(Send_Go), 32'd0);
      check("t1_c3_busy",    32'(tx_busy), 32'd1);
      go_expect = 1;
      repeat (10) cyc();
      pulse_done();
      check("t1_idle_busy",  32'(tx_busy), 32'd0);
      check("t1_idle_data",  32'(Data),    32'hA5);

      // Test 2: five back-to-back bytes, each acknowledged 100 cycles after its Send_Go.
      for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
      for (int i = 0; i < 5; i++) begin
         go_expect++;
         wait_go(go_expect);
         repeat (99) cyc();
         pulse_done();
      end
      cyc();
      check("t2_count", 32'(count),       32'd0);
      check("t2_empty", 32'(empty),       32'd1);
      check("t2_busy",  32'(tx_busy),     32'd0);
      check("t2_sb",    32'(expq.size()), 32'd0);

      // Test 3: hold Tx_done off. One byte goes in flight, 16 more fill the FIFO, and the 17th overflows.
      push(8'h10, 1'b1);
      go_expect++;
      wait_go(go_expect);
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
      check("t3_full",       32'(full),     32'd1);
      check("t3_count",      32'(count),    32'd16);
      check("t3_no_ovf",     32'(overflow), 32'd0);
      push(8'h77, 1'b0);
      check("t3_ovf_pulse",  32'(overflow), 32'd1);
      check("t3_ovf_count",  32'(count),    32'd16);
      cyc();
      check("t3_ovf_clear",  32'(overflow), 32'd0);

      // Test 4: the FIFO is full in IDLE, so a write and a pop land on the same edge.
      pulse_done();
      push(8'hEE, 1'b0);
      check("t4_count",    32'(count),    32'd15);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_full",     32'(full),     32'd0);
      check("t4_send_go",  32'(Send_Go),  32'd1);
      drain(16);
      cyc();
      check("t4_count_end", 32'(count),       32'd0);
      check("t4_empty_end", 32'(empty),       32'd1);
      check("t4_sb",        32'(expq.size()), 32'd0);

      // Test 5: reset during WAIT with three bytes queued.
      push(8'h40, 1'b1);
      push(8'h41, 1'b0);
      push(8'h42, 1'b0);
      push(8'h43, 1'b0);
      go_expect++;
      wait_go(go_expect);
      check("t5_pre_count", 32'(count),   32'd3);
      check("t5_pre_busy",  32'(tx_busy), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("t5_empty",   32'(empty),   32'd1);
      check("t5_count",   32'(count),   32'd0);
      check("t5_send_go", 32'(Send_Go), 32'd0);
      check("t5_busy",    32'(tx_busy), 32'd0);
      pulse_done();
      repeat (4) cyc();
      check("t5_no_go", 32'(sg_count), 32'(go_expect));

      // Test 6: a spurious Tx_done while IDLE and empty.
      pulse_done();
      cyc();
      check("t6_busy",    32'(tx_busy),  32'd0);
      check("t6_count",   32'(count),    32'd0);
      check("t6_empty",   32'(empty),    32'd1);
      check("t6_send_go", 32'(Send_Go),  32'd0);
      repeat (3) cyc();
      check("t6_no_go",   32'(sg_count), 32'(go_expect));

      // The block still transmits normally afterwards.
      push(8'h55, 1'b1);
      drain(1);
      cyc();
      check("end_sb",    32'(expq.size()), 32'd0);
      check("end_empty", 32'(empty),       32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
